instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 7, meaning the word-address width of the program memory.
REQ-002 SHALL have parameter RESET_PC, default 0, meaning the first word address fetched after reset.
REQ-003 SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, meaning the reset, which is asynchronous and active-low.
REQ-005 SHALL have port mem_addr, output, ADDR_WIDTH bits, meaning the word address to program memory (synchronous read, data one cycle later).
REQ-006 SHALL have port mem_instr, input, 32 bits, meaning program memory data for the mem_addr of the previous cycle.
REQ-007 SHALL have port stall, input, 1 bit, meaning decode cannot accept an instruction this cycle.
REQ-008 SHALL have port redirect, input, 1 bit, meaning a branch/jump taken; restart fetch at redirect_pc.
REQ-009 SHALL have port redirect_pc, input, ADDR_WIDTH bits, meaning the redirect target word address.
REQ-010 SHALL have port if_valid, output, 1 bit, meaning if_instr/if_pc hold a valid instruction.
REQ-011 SHALL have port if_pc, output, ADDR_WIDTH bits, meaning the address of if_instr.
REQ-012 SHALL have port if_instr, output, 32 bits, meaning the fetched instruction, registered.

Function
REQ-013 SHALL implement states BOOT, RUN, HOLD; reset enters BOOT.
REQ-014 SHALL, in BOOT, drive mem_addr=RESET_PC and issue nothing; after one cycle it SHALL go to RUN with an issue of RESET_PC.
REQ-015 SHALL drive mem_addr combinationally from the pc register.
REQ-016 SHALL, in RUN with stall=0, increment pc by 1 per cycle modulo 2^ADDR_WIDTH (wrap from all-ones to 0), tracking the in-flight address.
REQ-017 SHALL register mem_instr into if_instr and the in-flight address into if_pc one cycle after issue, asserting if_valid; first if_valid SHALL be high in the 3rd cycle after reset deasserts, with if_pc=RESET_PC.
REQ-018 SHALL, on stall=1 with if_valid=1, hold if_valid/if_pc/if_instr and pc, capture the in-flight response into a 1-entry skid buffer, and enter HOLD.
REQ-019 SHALL, in HOLD, issue no new address and keep the skid entry stable for any stall duration.
REQ-020 SHALL, on stall falling, present the skid entry on the next edge, resume issuing at pc in the same cycle, and return to RUN with no lost or duplicated instruction.
REQ-021 SHALL, on redirect=1 (any state), set pc=redirect_pc, discard in-flight and skid entries, deassert if_valid next edge, and enter RUN; first if_valid from the target SHALL be two cycles after redirect.
REQ-022 SHALL give redirect priority over stall when asserted together.
REQ-023 SHALL ignore stall while if_valid=0 (nothing to hold).

Reset
REQ-024 SHALL, on reset low, immediately force pc=RESET_PC, if_valid=0, if_pc=0, if_instr=0, skid empty, in-flight flag clear, state BOOT.
REQ-025 SHALL, on reset asserted mid-HOLD or mid-redirect, drop all pending instructions, with no output pulse on release.

Configuration
REQ-026 SHALL, when macro INSTR_FETCH_PERF_CNT_EN is defined, add output fetch_count (16 bits, reset 0) that increments on each cycle where if_valid=1 and stall=0, saturating at 16'hFFFF.
REQ-027 SHALL, without INSTR_FETCH_PERF_CNT_EN, omit fetch_count and its logic; all other behaviour SHALL be identical.

Verification
REQ-028 SHALL cover sequential fetch: memory words 0..11 preloaded, no stall -> if_pc 0,1,2,...,11 on consecutive cycles from cycle 3, each if_instr matching the word.
REQ-029 SHALL cover stall: stall high 4 cycles while if_pc=3 -> if_pc stays 3 for 5 cycles, then 4,5,6 with no gap or repeat.
REQ-030 SHALL cover redirect: redirect=1, redirect_pc=9 while if_pc=5 -> if_valid low 1 cycle, then if_pc=9,10,...
REQ-031 SHALL cover simultaneous events: stall=1 and redirect=1 same cycle, redirect_pc=2 -> redirect taken, output sequence restarts at 2.
REQ-032 SHALL cover wrap and reset: ADDR_WIDTH=3, run past 7 -> if_pc 7 then 0; reset pulsed low mid-stall -> if_valid=0 immediately, restart at RESET_PC.
REQ-033 SHALL cover counter: with INSTR_FETCH_PERF_CNT_EN, 10 delivered instructions incl. 3 stall cycles -> fetch_count=10.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: sequential word fetch from a synchronous-read program
// memory, one-entry skid buffer for decode stalls, redirect on taken branches.
// Optional fetch counter enabled by the INSTR_FETCH_PERF_CNT_EN macro.
module instr_fetch #(
  parameter int ADDR_WIDTH = 7,
  parameter int RESET_PC   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_instr,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  if_valid,
  output logic [ADDR_WIDTH-1:0] if_pc,
  output logic [31:0]           if_instr
`ifdef INSTR_FETCH_PERF_CNT_EN
  ,
  output logic [15:0]           fetch_count
`endif
);

  localparam int DATA_W = 32;
  localparam logic [ADDR_WIDTH-1:0] RST_PC = ADDR_WIDTH'(RESET_PC);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] pc;
  logic                  vld_p0;
  logic [ADDR_WIDTH-1:0] pc_p0;
  logic                  skid_vld;
  logic [ADDR_WIDTH-1:0] skid_pc;
  logic [DATA_W-1:0]     skid_instr;

  logic issue;
  logic advance;
  logic capture;
  logic release_skid;
  logic flush;

  function automatic logic [ADDR_WIDTH-1:0] pc_inc(input logic [ADDR_WIDTH-1:0] a);
    return a + ADDR_WIDTH'(1);
  endfunction

  // A redirect presents its target in the same cycle so the target's data
  // arrives one cycle later and if_valid drops for exactly one cycle.
  assign mem_addr = redirect ? redirect_pc : pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    issue        = 1'b0;
    advance      = 1'b0;
    capture      = 1'b0;
    release_skid = 1'b0;
    flush        = 1'b0;
    if (redirect) begin
      flush     = 1'b1;
      issue     = 1'b1;
      state_nxt = RUN;
    end else begin
      case (state)
        BOOT: begin
          issue     = 1'b1;
          state_nxt = RUN;
        end
        RUN: begin
          if (stall && if_valid) begin
            capture   = 1'b1;
            state_nxt = HOLD;
          end else begin
            issue   = 1'b1;
            advance = 1'b1;
          end
        end
        HOLD: begin
          if (!stall) begin
            issue        = 1'b1;
            release_skid = 1'b1;
            state_nxt    = RUN;
          end
        end
        default: state_nxt = BOOT;
      endcase
    end
  end

  // p0: address issued last cycle, its data is on mem_instr now
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc       <= RST_PC;
      vld_p0   <= 1'b0;
      skid_vld <= 1'b0;
    end else begin
      if (issue) pc <= pc_inc(mem_addr);
      vld_p0 <= issue;
      if (flush || release_skid) skid_vld <= 1'b0;
      else if (capture)          skid_vld <= vld_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) pc_p0 <= mem_addr;
    if (capture) begin
      skid_pc    <= pc_p0;
      skid_instr <= mem_instr;
    end
  end

  // p1: registered instruction handed to decode
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_instr <= '0;
    end else if (flush) begin
      if_valid <= 1'b0;
    end else if (advance) begin
      if_valid <= vld_p0;
      if_pc    <= pc_p0;
      if_instr <= mem_instr;
    end else if (release_skid) begin
      if_valid <= skid_vld;
      if_pc    <= skid_pc;
      if_instr <= skid_instr;
    end
  end

`ifdef INSTR_FETCH_PERF_CNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_count <= 16'd0;
    end else if (if_valid && !stall) begin
      fetch_count <= sat_inc(fetch_count);
    end
  end
`endif

endmodule
